// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: pipeline control in from the hazard unit, instruction memory
// traffic, and the IF/ID register contents out to decode.
interface if_fetch_stage_if;
   logic        PC_Wr;
   logic        IFID_Wr;
   logic        IFID_Flush;
   logic        is_J;
   logic        is_B;
   logic        trq;
   logic [31:0] br_target;
   logic [31:0] jr_target;
   logic [31:0] ex_pc;
   logic        ex_valid;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] PC;
   logic [31:0] IFID_Instruct;
   logic [31:0] IFID_PC4;
   logic        IFID_Valid;
   logic [31:0] epc;

   modport master (
      output PC_Wr, IFID_Wr, IFID_Flush, is_J, is_B, trq,
      output br_target, jr_target, ex_pc, ex_valid, imem_rdata,
      input  imem_addr, PC, IFID_Instruct, IFID_PC4, IFID_Valid, epc
   );

   modport slave (
      input  PC_Wr, IFID_Wr, IFID_Flush, is_J, is_B, trq,
      input  br_target, jr_target, ex_pc, ex_valid, imem_rdata,
      output imem_addr, PC, IFID_Instruct, IFID_PC4, IFID_Valid, epc
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, next-PC priority select, IF/ID pipeline register
// and the interrupt return address capture.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] IRQ_VEC  = 32'h8000_0004
) (
   input  logic              clk,
   input  logic              reset,
   if_fetch_stage_if.slave   bus
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] epc_q, epc_d;

   logic [31:0] pc4;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        is_jr;
   logic [31:0] jtarget;

   assign pc4    = pc_q + 32'd4;
   assign opcode = instr_q[31:26];
   assign funct  = instr_q[5:0];
   assign is_jr  = (opcode == 6'b000000) &&
                   ((funct == 6'b001000) || (funct == 6'b001001));
   // jr/jalr take the forwarded register verbatim; j/jal splice into the PC4 region.
   assign jtarget = is_jr ? bus.jr_target : {pc4_q[31:28], instr_q[25:0], 2'b00};

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      epc_d   = epc_q;

      if (bus.trq)            pc_d = IRQ_VEC;
      else if (bus.is_B)      pc_d = bus.br_target;
      else if (!bus.PC_Wr)    pc_d = pc_q;
      else if (bus.is_J)      pc_d = jtarget;
      else                    pc_d = pc4;

      // A stalled IF/ID must keep a jr in place even when the flush is asserted.
      if (bus.trq || bus.is_B) begin
         instr_d = 32'd0;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else if (!bus.IFID_Wr) begin
         instr_d = instr_q;
         pc4_d   = pc4_q;
         valid_d = valid_q;
      end else if (bus.IFID_Flush) begin
         instr_d = 32'd0;
         pc4_d   = 32'd0;
         valid_d = 1'b0;
      end else begin
         instr_d = bus.imem_rdata;
         pc4_d   = pc4;
         valid_d = 1'b1;
      end

      // Return to the oldest instruction that the interrupt squashes.
      if (bus.trq) begin
         if (bus.ex_valid)   epc_d = bus.ex_pc;
         else if (valid_q)   epc_d = pc4_q - 32'd4;
         else                epc_d = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         epc_q   <= 32'd0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         epc_q   <= epc_d;
      end
   end

   assign bus.imem_addr     = pc_q;
   assign bus.PC            = pc_q;
   assign bus.IFID_Instruct = instr_q;
   assign bus.IFID_PC4      = pc4_q;
   assign bus.IFID_Valid    = valid_q;
   assign bus.epc           = epc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: hand-computed PC, IF/ID and epc values per cycle.
module tb_if_fetch_stage;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;

   if_fetch_stage_if bus ();

   if_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      bus.PC_Wr      = 1'b1;
      bus.IFID_Wr    = 1'b1;
      bus.IFID_Flush = 1'b0;
      bus.is_J       = 1'b0;
      bus.is_B       = 1'b0;
      bus.trq        = 1'b0;
      bus.ex_valid   = 1'b0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
      check_vec({tag, "_instr"}, bus.IFID_Instruct, instr);
      check_vec({tag, "_pc4"},   bus.IFID_PC4, pc4);
      check_vec({tag, "_valid"}, {31'd0, bus.IFID_Valid}, {31'd0, valid});
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      idle_ctrl();
      bus.br_target  = 32'd0;
      bus.jr_target  = 32'd0;
      bus.ex_pc      = 32'd0;
      bus.imem_rdata = 32'h2108_0001;
      reset = 1'b1;

      // 1: reset then free run
      step();
      step();
      check_vec("rst_pc", bus.PC, 32'h8000_0000);
      check_vec("rst_addr", bus.imem_addr, 32'h8000_0000);
      check_vec("rst_epc", bus.epc, 32'd0);
      check_ifid("rst", 32'd0, 32'd0, 1'b0);
      reset = 1'b0;
      step();
      check_vec("run1_pc", bus.PC, 32'h8000_0004);
      check_ifid("run1", 32'h2108_0001, 32'h8000_0004, 1'b1);
      bus.imem_rdata = 32'h0800_0100;
      step();
      check_vec("run2_pc", bus.PC, 32'h8000_0008);
      check_vec("run2_addr", bus.imem_addr, 32'h8000_0008);
      check_ifid("run2", 32'h0800_0100, 32'h8000_0008, 1'b1);

      // 2: j 0x100 in IF/ID
      step();
      check_ifid("jload", 32'h0800_0100, 32'h8000_000C, 1'b1);
      bus.is_J = 1'b1;
      bus.IFID_Flush = 1'b1;
      step();
      check_vec("j_pc", bus.PC, 32'h8000_0400);
      check_ifid("j_sq", 32'd0, 32'd0, 1'b0);
      idle_ctrl();

      // 3: stalled jr keeps its slot, then jumps
      bus.imem_rdata = 32'h03E0_0008;
      step();
      check_ifid("jrload", 32'h03E0_0008, 32'h8000_0404, 1'b1);
      bus.PC_Wr = 1'b0;
      bus.IFID_Wr = 1'b0;
      bus.is_J = 1'b1;
      bus.IFID_Flush = 1'b1;
      bus.jr_target = 32'h1234_5678;
      step();
      check_vec("jrstall_pc", bus.PC, 32'h8000_0404);
      check_ifid("jrstall", 32'h03E0_0008, 32'h8000_0404, 1'b1);
      bus.PC_Wr = 1'b1;
      bus.IFID_Wr = 1'b1;
      bus.jr_target = 32'h0000_2000;
      step();
      check_vec("jr_pc", bus.PC, 32'h0000_2000);
      check_ifid("jr_sq", 32'd0, 32'd0, 1'b0);
      idle_ctrl();

      // 4: branch overrides PC stall and IF/ID stall
      bus.imem_rdata = 32'h2108_0001;
      step();
      check_ifid("brpre", 32'h2108_0001, 32'h0000_2004, 1'b1);
      bus.is_B = 1'b1;
      bus.br_target = 32'h8000_0100;
      bus.PC_Wr = 1'b0;
      bus.IFID_Wr = 1'b0;
      step();
      check_vec("br_pc", bus.PC, 32'h8000_0100);
      check_ifid("br_sq", 32'd0, 32'd0, 1'b0);
      idle_ctrl();

      // 5: interrupts
      step();
      check_vec("irqpre_pc", bus.PC, 32'h8000_0104);
      bus.trq = 1'b1;
      bus.ex_valid = 1'b1;
      bus.ex_pc = 32'h8000_0010;
      bus.is_B = 1'b1;
      bus.PC_Wr = 1'b0;
      step();
      check_vec("irq1_pc", bus.PC, 32'h8000_0004);
      check_vec("irq1_epc", bus.epc, 32'h8000_0010);
      check_ifid("irq1_sq", 32'd0, 32'd0, 1'b0);
      idle_ctrl();
      for (int i = 0; i < 5; i++) step();
      check_vec("epc_hold", bus.epc, 32'h8000_0010);
      check_ifid("irq2pre", 32'h2108_0001, 32'h8000_0018, 1'b1);
      bus.trq = 1'b1;
      bus.ex_pc = 32'hDEAD_BEEF;
      step();
      check_vec("irq2_pc", bus.PC, 32'h8000_0004);
      check_vec("irq2_epc", bus.epc, 32'h8000_0014);
      step();
      check_vec("irq3_epc", bus.epc, 32'h8000_0004);
      check_vec("irq3_pc", bus.PC, 32'h8000_0004);
      idle_ctrl();

      // 6: PC wrap and reset during a stall
      bus.is_B = 1'b1;
      bus.br_target = 32'hFFFF_FFFC;
      step();
      check_vec("wrpre_pc", bus.PC, 32'hFFFF_FFFC);
      idle_ctrl();
      step();
      check_vec("wrap_pc", bus.PC, 32'h0000_0000);
      check_ifid("wrap", 32'h2108_0001, 32'h0000_0000, 1'b1);
      bus.PC_Wr = 1'b0;
      bus.IFID_Wr = 1'b0;
      bus.trq = 1'b1;
      reset = 1'b1;
      step();
      check_vec("rst2_pc", bus.PC, 32'h8000_0000);
      check_vec("rst2_epc", bus.epc, 32'd0);
      check_ifid("rst2", 32'd0, 32'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
